// File: rtl/vx_flush_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module   : vx_flush_ctrl_if
// Brief    : Handshake/bus bundle between a bank tag stage and its flush sequencer.
// Revision : 1.0 - initial release
// ============================================================================
interface vx_flush_ctrl_if #(
    parameter int LSB = 6
);
    logic           stall;
    logic           flush_req_valid;
    logic           flush_req_ready;
    logic           flush_rsp_valid;
    logic           flush_rsp_ready;
    logic           flush_valid;
    logic [LSB-1:0] flush_addr;
    logic           busy;

    modport master (
        output stall,
        output flush_req_valid,
        output flush_rsp_ready,
        input  flush_req_ready,
        input  flush_rsp_valid,
        input  flush_valid,
        input  flush_addr,
        input  busy
    );

    modport slave (
        input  stall,
        input  flush_req_valid,
        input  flush_rsp_ready,
        output flush_req_ready,
        output flush_rsp_valid,
        output flush_valid,
        output flush_addr,
        output busy
    );
endinterface
`default_nettype wire

// File: rtl/vx_flush_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : vx_flush_ctrl
// Brief    : Per-bank tag-store invalidation sequencer (post-reset init sweep
//            plus request/acknowledge driven flush sweeps).
// Revision : 1.0 - initial release
// ============================================================================
module vx_flush_ctrl #(
    parameter int CACHE_ID        = 0,
    parameter int BANK_ID         = 0,
    parameter int CACHE_SIZE      = 4096,
    parameter int CACHE_LINE_SIZE = 64,
    parameter int NUM_BANKS       = 1,
    parameter int WORD_SIZE       = 4
) (
    input  wire logic         clk,
    input  wire logic         reset,
    vx_flush_ctrl_if.slave    bus
);
    localparam int LINES_PER_BANK = CACHE_SIZE / (CACHE_LINE_SIZE * NUM_BANKS);
    localparam int LSB            = (LINES_PER_BANK > 1) ? $clog2(LINES_PER_BANK) : 1;
    localparam logic [LSB-1:0] LAST_LINE = LSB'(LINES_PER_BANK - 1);

    // Identification parameters only matter for tracing; reject nonsense values.
    if (LINES_PER_BANK < 1 || WORD_SIZE < 1 || CACHE_ID < 0 ||
        BANK_ID < 0 || BANK_ID >= NUM_BANKS) begin : g_param_check
        $error("vx_flush_ctrl: illegal parameter combination");
    end

    typedef enum logic [1:0] {
        S_INIT  = 2'd0,
        S_IDLE  = 2'd1,
        S_FLUSH = 2'd2,
        S_RESP  = 2'd3
    } state_t;

    state_t         state_q, state_d;
    logic [LSB-1:0] cnt_q, cnt_d;
    logic           w_sweeping;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_INIT;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            S_INIT, S_FLUSH: begin
                // A stalled cycle does not land the tag write, so the line is retried.
                if (!bus.stall) begin
                    if (cnt_q == LAST_LINE) begin
                        cnt_d   = '0;
                        state_d = (state_q == S_INIT) ? S_IDLE : S_RESP;
                    end else begin
                        cnt_d = cnt_q + LSB'(1);
                    end
                end
            end
            S_IDLE: begin
                if (bus.flush_req_valid) begin
                    state_d = S_FLUSH;
                    cnt_d   = '0;
                end
            end
            S_RESP: begin
                if (bus.flush_rsp_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_INIT;
                cnt_d   = '0;
            end
        endcase
    end

    // Outputs decode registered state only; reset forces the quiescent-but-busy view.
    assign w_sweeping          = (state_q == S_INIT) || (state_q == S_FLUSH);
    assign bus.flush_valid     = w_sweeping && !reset;
    assign bus.flush_addr      = cnt_q;
    assign bus.busy            = w_sweeping || reset;
    assign bus.flush_req_ready = (state_q == S_IDLE) && !reset;
    assign bus.flush_rsp_valid = (state_q == S_RESP) && !reset;

endmodule
`default_nettype wire
